// File: rtl/prime_check.sv
`default_nettype none
// ============================================================================
//  Module      : prime_check
//  Description : Trial-division primality tester. It drives an external
//                divide/modulo unit with divisors 2,3,5,7,9,... and stops at
//                the first exact divisor, or once quotient < divisor (which
//                means d*d > n). No multiplier is used.
//  Revision    : 1.0  initial release
// ============================================================================
module prime_check #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_go,
    input  logic [WIDTH-1:0] i_n,
    output logic             o_ready,
    output logic             o_is_prime,
    output logic             o_error,
    output logic [WIDTH-1:0] o_factor,
    output logic             o_dm_go,
    output logic [WIDTH-1:0] o_dm_a,
    output logic [WIDTH-1:0] o_dm_b,
    input  logic             i_dm_ready,
    input  logic             i_dm_error,
    input  logic [WIDTH-1:0] i_dm_div,
    input  logic [WIDTH-1:0] i_dm_mod
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_ZERO  = '0;
    localparam logic [WIDTH-1:0] c_TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] c_THREE = WIDTH'(3);
    localparam logic [WIDTH-1:0] c_FOUR  = WIDTH'(4);

    state_t           r_state;
    logic             r_go_q;
    logic             r_ready;
    logic             r_is_prime;
    logic             r_error;
    logic [WIDTH-1:0] r_factor;
    logic             r_dm_go;
    logic [WIDTH-1:0] r_dm_a;
    logic [WIDTH-1:0] r_dm_b;
    logic [WIDTH-1:0] r_d;

    logic             w_start;
    logic [WIDTH-1:0] w_d_next;

    // Start is a 0->1 transition of go; history is tracked every cycle so a
    // held-high go can never look like a fresh request later.
    assign w_start  = i_go & ~r_go_q;
    // After 2 only odd divisors are tried.
    assign w_d_next = (r_d == c_TWO) ? c_THREE : (r_d + c_TWO);

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_go_q     <= 1'b0;
            r_ready    <= 1'b1;
            r_is_prime <= 1'b0;
            r_error    <= 1'b0;
            r_factor   <= c_ZERO;
            r_dm_go    <= 1'b0;
            r_dm_a     <= c_ZERO;
            r_dm_b     <= c_ZERO;
            r_d        <= c_TWO;
        end else begin
            r_go_q <= i_go;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_error  <= 1'b0;
                        r_factor <= c_ZERO;
                        if (i_n < c_TWO) begin
                            r_is_prime <= 1'b0;
                        end else if (i_n < c_FOUR) begin
                            r_is_prime <= 1'b1;
                        end else begin
                            r_is_prime <= 1'b0;
                            r_d        <= c_TWO;
                            r_dm_a     <= i_n;
                            r_dm_b     <= c_TWO;
                            r_dm_go    <= 1'b1;
                            r_ready    <= 1'b0;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // Single-cycle start pulse per division.
                    r_dm_go <= 1'b0;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    // Give the divider time to drop a stale ready.
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_dm_ready) begin
                        if (i_dm_error) begin
                            r_error    <= 1'b1;
                            r_is_prime <= 1'b0;
                            r_ready    <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (i_dm_mod == c_ZERO) begin
                            r_factor   <= r_d;
                            r_is_prime <= 1'b0;
                            r_ready    <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (i_dm_div < r_d) begin
                            // quotient < divisor implies d*d > n: no factor left
                            r_is_prime <= 1'b1;
                            r_ready    <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_d     <= w_d_next;
                            r_dm_b  <= w_d_next;
                            r_dm_go <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_is_prime = r_is_prime;
    assign o_error    = r_error;
    assign o_factor   = r_factor;
    assign o_dm_go    = r_dm_go;
    assign o_dm_a     = r_dm_a;
    assign o_dm_b     = r_dm_b;

endmodule
`default_nettype wire

// File: tb/tb_prime_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prime_check
//  Description : Self-checking bench for prime_check with a behavioural
//                divide/modulo unit and a trial-division reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prime_check;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_go = 1'b0;
    logic [WIDTH-1:0] i_n = '0;
    logic             o_ready, o_is_prime, o_error, o_dm_go;
    logic [WIDTH-1:0] o_factor, o_dm_a, o_dm_b;
    logic             dm_ready, dm_error;
    logic [WIDTH-1:0] dm_div, dm_mod;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit m_valid = 1'b0;
    int m_prime, m_factor, m_error;
    int cur_n;
    int div_q[$];
    int exp_q[$];
    bit err_mode = 1'b0;
    bit stall    = 1'b0;

    always #5 clk = ~clk;

    prime_check #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_go       (i_go),
        .i_n        (i_n),
        .o_ready    (o_ready),
        .o_is_prime (o_is_prime),
        .o_error    (o_error),
        .o_factor   (o_factor),
        .o_dm_go    (o_dm_go),
        .o_dm_a     (o_dm_a),
        .o_dm_b     (o_dm_b),
        .i_dm_ready (dm_ready),
        .i_dm_error (dm_error),
        .i_dm_div   (dm_div),
        .i_dm_mod   (dm_mod)
    );

    // Behavioural divmod: rising-edge triggered, random latency, ready stays
    // high (with stale results) while idle.
    logic             dmg_q;
    int               dm_cnt;
    logic [WIDTH-1:0] pend_a, pend_b;
    always @(posedge clk) begin
        if (rst) begin
            dm_ready <= 1'b1; dm_error <= 1'b0; dm_div <= '0; dm_mod <= '0;
            dmg_q <= 1'b0; dm_cnt <= 0; pend_a <= '0; pend_b <= '0;
        end else begin
            dmg_q <= o_dm_go;
            if (o_dm_go && !dmg_q) begin
                dm_ready <= 1'b0;
                dm_cnt   <= int'($urandom_range(1, 4));
                pend_a   <= o_dm_a;
                pend_b   <= o_dm_b;
            end else if (!dm_ready && !stall) begin
                if (dm_cnt <= 1) begin
                    dm_ready <= 1'b1;
                    dm_error <= err_mode;
                    dm_div   <= (pend_b != 0) ? pend_a / pend_b : '1;
                    dm_mod   <= (pend_b != 0) ? pend_a % pend_b : '0;
                end else begin
                    dm_cnt <= dm_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", name, act, exp, cur_n);
        end
    endtask

    // Smallest divisor by plain trial division over all integers.
    function automatic void ref_model(input int n, output int p, output int f);
        p = 0; f = 0;
        if (n < 2) return;
        for (int k = 2; k * k <= n; k++) begin
            if (n % k == 0) begin f = k; return; end
        end
        p = 1;
    endfunction

    // Divisors the tester must try: 2,3,5,7,... up to first hit or d*d > n.
    task automatic build_exp(input int n, input bit err);
        int d;
        exp_q.delete();
        if (n < 4) return;
        d = 2;
        forever begin
            exp_q.push_back(d);
            if (err || (n % d == 0) || (d * d > n)) break;
            d = (d == 2) ? 3 : d + 2;
        end
    endtask

    // Record every issued division; dm_go must be a one-cycle pulse.
    logic dmgo_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            dmgo_prev <= 1'b0;
        end else begin
            if (o_dm_go) begin
                div_q.push_back(int'(o_dm_b));
                check("dm_go_pulse_width", int'(dmgo_prev), 0);
                check("dm_a_value", int'(o_dm_a), cur_n);
            end
            dmgo_prev <= o_dm_go;
        end
    end

    // Result comparison on every idle cycle.
    always @(negedge clk) begin
        if (m_valid && !rst && o_ready) begin
            n_tests++;
            if (int'(o_is_prime) != m_prime || int'(o_factor) != m_factor ||
                int'(o_error) != m_error) begin
                n_fail++;
                $display("FAIL idle_results n=%0d: got prime=%0d factor=%0d error=%0d expected prime=%0d factor=%0d error=%0d",
                         cur_n, o_is_prime, o_factor, o_error, m_prime, m_factor, m_error);
            end
        end
    end

    task automatic run_test(input int n, input bit hold, input bit err);
        int p, f;
        div_q.delete();
        cur_n    = n;
        err_mode = err;
        @(posedge clk); #1;
        i_n  = WIDTH'(n);
        i_go = 1'b1;
        @(posedge clk); #1;
        ref_model(n, p, f);
        if (err && n >= 4) begin
            m_prime = 0; m_factor = 0; m_error = 1;
        end else begin
            m_prime = p; m_factor = f; m_error = 0;
        end
        if (!hold) i_go = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (o_ready) break;
            @(posedge clk); #1;
        end
        check("ready_timeout", int'(o_ready), 1);
        if (hold) begin
            repeat (6) @(posedge clk);
            #1;
            i_go = 1'b0;
        end
        @(posedge clk); #1;
        build_exp(n, err);
        check("div_count", div_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < div_q.size(); i++)
            check("div_seq", div_q[i], exp_q[i]);
        err_mode = 1'b0;
    endtask

    initial begin
        int p, f, n;
        // model pins
        ref_model(97, p, f);    check("model_97_prime", p, 1);
        ref_model(91, p, f);    check("model_91_factor", f, 7);
        ref_model(65535, p, f); check("model_65535_factor", f, 3);
        build_exp(97, 1'b0);    check("model_97_divs", exp_q.size(), 6);

        cur_n = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", int'(o_ready), 1);
        check("rst_dm_go", int'(o_dm_go), 0);
        check("rst_dm_a", int'(o_dm_a), 0);
        check("rst_dm_b", int'(o_dm_b), 0);
        check("rst_factor", int'(o_factor), 0);
        m_prime = 0; m_factor = 0; m_error = 0; m_valid = 1'b1;

        run_test(1, 1'b0, 1'b0);
        check("n1_ready", int'(o_ready), 1);
        check("n1_prime", int'(o_is_prime), 0);
        run_test(97, 1'b0, 1'b0);
        check("n97_prime", int'(o_is_prime), 1);
        check("n97_factor", int'(o_factor), 0);
        run_test(91, 1'b0, 1'b0);
        check("n91_factor", int'(o_factor), 7);
        run_test(65535, 1'b0, 1'b0);
        check("n65535_factor", int'(o_factor), 3);
        run_test(2, 1'b0, 1'b0);
        check("n2_prime", int'(o_is_prime), 1);
        run_test(4, 1'b0, 1'b0);
        check("n4_factor", int'(o_factor), 2);
        run_test(97, 1'b0, 1'b1);
        check("err_flag", int'(o_error), 1);
        check("err_prime", int'(o_is_prime), 0);
        run_test(91, 1'b0, 1'b0);
        check("err_cleared", int'(o_error), 0);
        run_test(25, 1'b1, 1'b0);          // go held across completion
        run_test(3, 1'b1, 1'b0);
        run_test(65521, 1'b0, 1'b0);       // largest 16-bit prime
        check("n65521_prime", int'(o_is_prime), 1);
        run_test(63001, 1'b0, 1'b0);       // 251*251
        check("n63001_factor", int'(o_factor), 251);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       n = int'($urandom_range(0, 30));
                1:       n = int'($urandom_range(0, 1000));
                default: n = int'($urandom_range(0, 65535));
            endcase
            run_test(n, bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 7) == 0));
        end

        // reset while waiting on a stalled divider
        stall = 1'b1;
        div_q.delete();
        cur_n = 97;
        @(posedge clk); #1;
        i_n = 16'd97; i_go = 1'b1;
        @(posedge clk); #1;
        i_go = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stall_busy", int'(o_ready), 0);
        m_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0;
        m_prime = 0; m_factor = 0; m_error = 0; m_valid = 1'b1;
        check("wrst_ready", int'(o_ready), 1);
        check("wrst_dm_go", int'(o_dm_go), 0);
        check("wrst_dm_a", int'(o_dm_a), 0);
        check("wrst_dm_b", int'(o_dm_b), 0);
        div_q.delete();
        repeat (20) @(posedge clk);
        #1;
        check("wrst_no_dm_go", div_q.size(), 0);

        // reset dominates a simultaneous start
        run_test(2, 1'b0, 1'b0);
        m_valid = 1'b0;
        i_n = 16'd3; i_go = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; i_go = 1'b0;
        m_prime = 0; m_factor = 0; m_error = 0; m_valid = 1'b1;
        check("rst_dom_prime", int'(o_is_prime), 0);
        check("rst_dom_ready", int'(o_ready), 1);
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
